cipher_frame_ctrl: RTL and testbench
====================================

CIPHER_FRAME_CTRL -- requirements
Module: cipher_frame_ctrl

Interface
REQ-001 The module SHALL expose these ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  frame command offered
- cmd_ready  out  1  controller can accept a command
- cmd_seed  in  8  keystream seed for the frame
- cmd_len  in  8  frame length in bytes; 0 means 256
- abort  in  1  synchronous frame cancel
- in_valid  in  1  plaintext/ciphertext byte offered
- in_ready  out  1  controller accepts the byte
- in_data  in  8  input byte
- out_valid  out  1  output byte valid; no backpressure
- out_data  out  8  in_data XOR keystream byte
- out_last  out  1  marks the final byte of the frame, qualified by out_valid
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse when a frame completes normally

Function
REQ-002 The FSM SHALL have four states: IDLE, SEED, STREAM and DRAIN.
REQ-003 In IDLE, cmd_ready SHALL be 1; on cmd_valid&cmd_ready the controller SHALL latch len (0->256, 9-bit count) and seed, then go to SEED.
REQ-004 SEED SHALL last exactly one cycle, driving the cipher load_seed=1 with seed_in equal to the latched seed, then go to STREAM.
REQ-005 In STREAM, in_ready SHALL be 1 while the remaining count is >0.
REQ-006 In STREAM, each in_valid&in_ready SHALL drive cipher encrypt_en=1 and data_in=in_data in the same cycle, and decrement the remaining count.
REQ-007 Cycles in STREAM with in_valid=0 SHALL drive encrypt_en=0, leaving the keystream unadvanced.
REQ-008 When the last byte is accepted, the FSM SHALL go to DRAIN with in_ready=0 from the next cycle.
REQ-009 Output latency SHALL be PIPE_LAT=2: a byte accepted in cycle N appears as out_valid=1 with out_data equal to the cipher data_out in cycle N+2.
REQ-010 A 2-deep valid/last shift register SHALL track the pipeline; out_last=1 only with the frame's final out_valid.
REQ-011 DRAIN SHALL return to IDLE in the cycle after out_last, asserting frame_done=1 for exactly that one cycle.
REQ-012 cmd_ready SHALL be 0 outside IDLE; commands offered while busy SHALL be held off, never dropped or queued.
REQ-013 abort in SEED, STREAM or DRAIN SHALL force IDLE on the next edge, clear both valid-pipeline stages (no out_valid/out_last for in-flight bytes), and produce no frame_done.
REQ-014 abort in IDLE SHALL be ignored; abort together with cmd_valid in IDLE SHALL mean no command is accepted.
REQ-015 out_data SHALL hold its last value when out_valid=0; the bench SHALL check it only when out_valid=1.

Reset
REQ-016 While rst_n=0, all of the following SHALL hold: FSM=IDLE, count=0, valid/last pipeline=0, out_valid=out_last=frame_done=0, out_data=0x00, busy=0, in_ready=0, cmd_ready=0.
REQ-017 cmd_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-018 Reset mid-frame SHALL discard the frame entirely and require a new command with a fresh seed.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding, PIPE_LAT=2 and the byte width 8.
REQ-020 One sub-module SHALL be instantiated: stream_cipher, with its clk/rst_n tied to the controller's and its load_seed, seed_in, encrypt_en and data_in driven exclusively by this controller.

Verification
REQ-021 Reset, then seed=0x5A, len=3, bytes 0x00/0x11/0x22 on back-to-back cycles -> out_valid on exactly 3 consecutive cycles starting 2 after the first accept, out_last on the 3rd, frame_done the next cycle.
REQ-022 Encrypt 4 bytes with seed=0xC3, then run a second frame with seed=0xC3 on the ciphertext -> output equals the original 4 plaintext bytes.
REQ-023 len=2 with in_valid gapped 0,1,0,0,1 -> exactly 2 out_valid pulses, each 2 cycles after its accept; output identical to the gap-free run.
REQ-024 abort asserted 1 cycle after the 2nd of len=5 bytes -> IDLE next cycle, no further out_valid, no frame_done, cmd_ready=1.
REQ-025 cmd_valid held high through an entire len=1 frame -> second command accepted only in the cycle IDLE is re-entered; len=0 frame -> exactly 256 out_valid pulses, out_last on the 256th.

Source files
------------

// File: rtl/cipher_frame_ctrl_pkg.sv
// Shared definitions for the cipher frame controller: FSM encoding, pipeline
// depth, byte/count widths and the keystream step used by the stream cipher.
package cipher_frame_ctrl_pkg;

    localparam int BYTE_W   = 8;
    localparam int PIPE_LAT = 2;
    localparam int CNT_W    = 9;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEED   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    // Keystream advances as an 8-bit LCG (odd increment, mult = 1 mod 4): full
    // period of 256, so no seed value locks the stream.
    localparam logic [BYTE_W-1:0] KS_MUL = 8'd5;
    localparam logic [BYTE_W-1:0] KS_INC = 8'h3B;

    function automatic logic [BYTE_W-1:0] ks_next(input logic [BYTE_W-1:0] ks);
        return ks * KS_MUL + KS_INC;
    endfunction

    function automatic logic [CNT_W-1:0] frame_len(input logic [BYTE_W-1:0] len);
        return (len == '0) ? CNT_W'(256) : CNT_W'(len);
    endfunction

endpackage

// File: rtl/cipher_frame_ctrl_stream_cipher.sv
// Byte stream cipher: XORs each enabled byte with the current keystream byte
// and registers the result; the keystream advances only on enabled bytes.
module stream_cipher
    import cipher_frame_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_seed,
    input  logic [BYTE_W-1:0] seed_in,
    input  logic              encrypt_en,
    input  logic [BYTE_W-1:0] data_in,
    output logic [BYTE_W-1:0] data_out
);

    logic [BYTE_W-1:0] ks_q, ks_d;
    logic [BYTE_W-1:0] dout_q, dout_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        ks_d   = ks_q;
        dout_d = dout_q;
        if (load_seed) begin
            ks_d = seed_in;
        end else if (encrypt_en) begin
            dout_d = data_in ^ ks_q;
            ks_d   = ks_next(ks_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ks_q   <= '0;
            dout_q <= '0;
        end else begin
            // NOTE: non-blocking updates so all flops sample pre-edge values.
            ks_q   <= ks_d;
            dout_q <= dout_d;
        end
    end

    assign data_out = dout_q;

endmodule

// File: rtl/cipher_frame_ctrl.sv
// Frame controller: accepts a seed/length command, streams that many bytes
// through the stream cipher and emits them two cycles later with a last flag.
module cipher_frame_ctrl
    import cipher_frame_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [BYTE_W-1:0] cmd_seed,
    input  logic [BYTE_W-1:0] cmd_len,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    output logic              out_valid,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              frame_done
);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BYTE_W-1:0]   seed_q, seed_d;
    logic [PIPE_LAT-1:0] vld_q, vld_d;
    logic [PIPE_LAT-1:0] last_q, last_d;
    logic [BYTE_W-1:0]   odata_q, odata_d;
    logic                done_q, done_d;
    logic                alive_q;

    logic                in_fire;
    logic                cmd_fire;
    logic                final_byte;
    logic [BYTE_W-1:0]   cipher_dout;

    // alive_q keeps cmd_ready low until the first edge after reset release.
    assign cmd_ready  = alive_q && (state_q == ST_IDLE);
    assign in_ready   = (state_q == ST_STREAM) && (cnt_q != '0);
    assign busy       = (state_q != ST_IDLE);
    assign in_fire    = in_valid && in_ready;
    assign cmd_fire   = cmd_valid && cmd_ready && !abort;
    assign final_byte = in_fire && (cnt_q == CNT_W'(1));

    assign out_valid  = vld_q[PIPE_LAT-1];
    assign out_last   = last_q[PIPE_LAT-1];
    assign out_data   = odata_q;
    assign frame_done = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seed_d  = seed_q;
        done_d  = 1'b0;
        vld_d   = {vld_q[PIPE_LAT-2:0], in_fire};
        last_d  = {last_q[PIPE_LAT-2:0], final_byte};
        odata_d = vld_q[0] ? cipher_dout : odata_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    cnt_d   = frame_len(cmd_len);
                    seed_d  = cmd_seed;
                    state_d = ST_SEED;
                end
            end
            ST_SEED: state_d = ST_STREAM;
            ST_STREAM: begin
                if (in_fire) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (final_byte) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_valid && out_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort drops every in-flight byte so the frame leaves no trace downstream.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            vld_d   = '0;
            last_d  = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            seed_q  <= '0;
            vld_q   <= '0;
            last_q  <= '0;
            odata_q <= '0;
            done_q  <= 1'b0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seed_q  <= seed_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            odata_q <= odata_d;
            done_q  <= done_d;
            alive_q <= 1'b1;
        end
    end

    stream_cipher u_cipher (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_seed  (state_q == ST_SEED),
        .seed_in    (seed_q),
        .encrypt_en (in_fire),
        .data_in    (in_data),
        .data_out   (cipher_dout)
    );

    a_last_has_valid: assert property (@(posedge clk) disable iff (!rst_n)
        out_last |-> out_valid);
    a_ready_only_idle: assert property (@(posedge clk) disable iff (!rst_n)
        cmd_ready |-> !busy);
    a_done_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
        frame_done |=> !frame_done);

endmodule

// File: tb/tb_cipher_frame_ctrl.sv
// Self-checking bench: drives framed traffic with random gaps/aborts and
// compares every output byte, its timing and the frame flags to a keystream model.
module tb_cipher_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready;
    logic [7:0] cmd_seed, cmd_len;
    logic       abort;
    logic       in_valid, in_ready;
    logic [7:0] in_data;
    logic       out_valid, out_last;
    logic [7:0] out_data;
    logic       busy, frame_done;

    always #5 clk = ~clk;

    cipher_frame_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_seed   (cmd_seed),
        .cmd_len    (cmd_len),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .frame_done (frame_done)
    );

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       last;
    } out_ev_t;

    out_ev_t outq[$];
    int      doneq[$];
    int      cyc;
    int      errors;
    int      checks;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one cycle and sample outputs on the falling edge.
    task automatic step();
        out_ev_t ev;
        @(posedge clk);
        cyc = cyc + 1;
        @(negedge clk);
        if (out_valid) begin
            ev.cyc  = cyc;
            ev.data = out_data;
            ev.last = out_last;
            outq.push_back(ev);
        end else begin
            check("last_without_valid", {31'd0, out_last}, 32'd0);
        end
        if (frame_done) doneq.push_back(cyc);
    endtask

    // Keystream byte idx of a frame: seed, then x -> 5x + 59 mod 256.
    function automatic logic [7:0] ks_at(input logic [7:0] seed, input int idx);
        int k;
        k = int'(seed);
        for (int j = 0; j < idx; j++) k = (k * 5 + 59) % 256;
        return 8'(k);
    endfunction

    task automatic run_frame(input logic [7:0] seed, input logic [7:0] len,
                             input logic [7:0] pt[$], input int pat[$],
                             input int gap_pct, input int abort_after,
                             input bit hold_cmd, output logic [7:0] got[$]);
        int  n, i, p, abort_cyc, guard, w, exp_n;
        int  acc[$];
        bit  v;
        n = (len == 8'd0) ? 256 : int'(len);
        outq.delete();
        doneq.delete();
        got.delete();
        check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);
        cmd_valid = 1'b1;
        cmd_seed  = seed;
        cmd_len   = len;
        step();
        if (!hold_cmd) cmd_valid = 1'b0;
        check("seed_busy", {31'd0, busy}, 32'd1);
        check("seed_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("seed_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        i = 0; p = 0; abort_cyc = -1; guard = 0;
        while (i < n && abort_cyc < 0 && guard < 4000) begin
            check("stream_in_ready", {31'd0, in_ready}, 32'd1);
            check("stream_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            if (p < pat.size()) v = (pat[p] != 0);
            else                v = ($urandom_range(0, 99) >= gap_pct);
            p = p + 1;
            in_valid = v;
            in_data  = pt[i];
            if (v) acc.push_back(cyc);
            step();
            guard = guard + 1;
            if (v) begin
                i = i + 1;
                if (abort_after > 0 && i == abort_after) begin
                    in_valid  = 1'b0;
                    abort     = 1'b1;
                    abort_cyc = cyc;
                    step();
                    abort = 1'b0;
                    check("abort_busy", {31'd0, busy}, 32'd0);
                    check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
                    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
                end
            end
        end
        in_valid = 1'b0;
        if (guard >= 4000) check("stream_guard", 32'(guard), 32'd0);
        if (abort_cyc >= 0) begin
            repeat (5) step();
            exp_n = 0;
            foreach (acc[k]) if (acc[k] + 2 <= abort_cyc) exp_n++;
        end else begin
            check("drain_in_ready", {31'd0, in_ready}, 32'd0);
            w = 0;
            while (doneq.size() == 0 && w < 12) begin
                step();
                w = w + 1;
            end
            check("done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
            check("done_busy", {31'd0, busy}, 32'd0);
            if (!hold_cmd) repeat (2) step();
            exp_n = n;
        end
        check("out_count", 32'(outq.size()), 32'(exp_n));
        for (int k = 0; k < outq.size() && k < exp_n; k++) begin
            got.push_back(outq[k].data);
            check("out_cycle", 32'(outq[k].cyc), 32'(acc[k] + 2));
            check("out_data", {24'd0, outq[k].data}, {24'd0, pt[k] ^ ks_at(seed, k)});
            check("out_last", {31'd0, outq[k].last},
                  {31'd0, (abort_cyc < 0) && (k == n - 1)});
        end
        check("done_count", 32'(doneq.size()), (abort_cyc < 0) ? 32'd1 : 32'd0);
        if (abort_cyc < 0 && doneq.size() > 0)
            check("done_cycle", 32'(doneq[0]), 32'(acc[n - 1] + 3));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] pt[$];
        logic [7:0] ct[$];
        logic [7:0] got[$];
        logic [7:0] g_gap[$];
        int         pat[$];
        int         n, ab;

        errors = 0; checks = 0; cyc = 0;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_seed = '0; cmd_len = '0;
        abort = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        rst_n = 1'b1;
        step();
        check("cmd_ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        // Basic three-byte frame, back-to-back input.
        pt = {8'h00, 8'h11, 8'h22};
        pat = {1, 1, 1};
        run_frame(8'h5A, 8'd3, pt, pat, 0, 0, 1'b0, got);

        // Encrypt then decrypt with the same seed restores the plaintext.
        pt.delete();
        for (int k = 0; k < 4; k++) pt.push_back(8'($urandom_range(0, 255)));
        ct.delete();
        for (int k = 0; k < 4; k++) ct.push_back(pt[k] ^ ks_at(8'hC3, k));
        pat.delete();
        run_frame(8'hC3, 8'd4, pt, pat, 0, 0, 1'b0, got);
        run_frame(8'hC3, 8'd4, ct, pat, 0, 0, 1'b0, got);
        for (int k = 0; k < 4 && k < got.size(); k++)
            check("roundtrip", {24'd0, got[k]}, {24'd0, pt[k]});

        // Gapped input must produce the same bytes as gap-free input.
        pt = {8'h3C, 8'hE1};
        pat = {0, 1, 0, 0, 1};
        run_frame(8'h77, 8'd2, pt, pat, 0, 0, 1'b0, g_gap);
        pat = {1, 1};
        run_frame(8'h77, 8'd2, pt, pat, 0, 0, 1'b0, got);
        check("gap_count", 32'(g_gap.size()), 32'(got.size()));
        for (int k = 0; k < 2 && k < g_gap.size() && k < got.size(); k++)
            check("gap_vs_nogap", {24'd0, g_gap[k]}, {24'd0, got[k]});

        // Abort one cycle after the second byte of a five-byte frame.
        pt = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        pat = {1, 1};
        run_frame(8'h9E, 8'd5, pt, pat, 0, 2, 1'b0, got);

        // Command held through a one-byte frame; the next is taken on IDLE re-entry.
        pt = {8'hA5};
        pat = {1};
        run_frame(8'h10, 8'd1, pt, pat, 0, 0, 1'b1, got);
        pt = {8'h5A};
        run_frame(8'h20, 8'd1, pt, pat, 0, 0, 1'b0, got);

        // Length field 0 means a 256-byte frame.
        pt.delete();
        for (int k = 0; k < 256; k++) pt.push_back(8'($urandom_range(0, 255)));
        pat.delete();
        run_frame(8'($urandom_range(0, 255)), 8'd0, pt, pat, 20, 0, 1'b0, got);

        // Abort in IDLE together with a command: nothing is accepted.
        cmd_valid = 1'b1; cmd_len = 8'd3; abort = 1'b1;
        step();
        check("idle_abort_no_accept", {31'd0, busy}, 32'd0);
        cmd_valid = 1'b0; abort = 1'b0;
        step();
        check("idle_abort_still_idle", {31'd0, busy}, 32'd0);

        // Random frames with random gaps and occasional aborts (including in DRAIN).
        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(1, 24);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
            pt.delete();
            for (int k = 0; k < n; k++) pt.push_back(8'($urandom_range(0, 255)));
            run_frame(8'($urandom_range(0, 255)), 8'(n), pt, pat, 30, ab, 1'b0, got);
        end

        // Reset mid-frame discards it; a fresh command restarts cleanly.
        cmd_valid = 1'b1; cmd_seed = 8'h44; cmd_len = 8'd10;
        step();
        cmd_valid = 1'b0;
        step();
        in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_data", {24'd0, out_data}, 32'd0);
        check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("midrst_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
        pt = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_frame(8'hB7, 8'd4, pt, pat, 25, 0, 1'b0, got);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
